// File: rtl/i2c_cmd_gen.sv
// rtl/i2c_cmd_gen.sv - turns single I2C read/write requests into i2c_master command streams
//
// Purpose:
//   Accepts one request at a time and emits the command beats an i2c_master
//   expects. A write becomes one write_multiple command. A read of N bytes becomes
//   N single-read commands, with START on the first and the caller's STOP on the last.
//   A NACK reported by the master aborts a read with a stop-only command. Completion
//   is reported with a one-cycle done/err pulse.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_*                        request channel (valid/ready)
//   m_axis_cmd_*                 command stream towards i2c_master (valid/ready)
//   master_busy, missed_ack      status from i2c_master
//   done, err                    completion pulse and its error flag
//   rd_remaining                 read commands not yet issued

module i2c_cmd_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req_address,
    input  logic       req_read,
    input  logic [7:0] req_len,
    input  logic       req_stop,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [6:0] m_axis_cmd_address,
    output logic       m_axis_cmd_start,
    output logic       m_axis_cmd_read,
    output logic       m_axis_cmd_write,
    output logic       m_axis_cmd_write_multiple,
    output logic       m_axis_cmd_stop,
    output logic       m_axis_cmd_valid,
    input  logic       m_axis_cmd_ready,
    input  logic       master_busy,
    input  logic       missed_ack,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_remaining
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_WR_CMD,
        ST_STOP_CMD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t     state_q;
    logic [6:0] addr_q;
    logic       stop_q;
    logic       abort_q;
    logic       first_q;
    logic [7:0] rd_rem_q;

    logic [6:0] cmd_addr_q;
    logic       cmd_start_q;
    logic       cmd_read_q;
    logic       cmd_wm_q;
    logic       cmd_stop_q;
    logic       cmd_valid_q;
    logic       done_q;
    logic       err_q;

    logic       cmd_hs;
    logic       in_xfer;

    assign cmd_hs  = cmd_valid_q & m_axis_cmd_ready;
    assign in_xfer = (state_q != ST_IDLE) && (state_q != ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 7'd0;
            stop_q      <= 1'b0;
            abort_q     <= 1'b0;
            first_q     <= 1'b0;
            rd_rem_q    <= 8'd0;
            cmd_addr_q  <= 7'd0;
            cmd_start_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_wm_q    <= 1'b0;
            cmd_stop_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Sticky NACK flag; acted on only at the next safe point of the read loop.
            if (in_xfer && missed_ack) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_address;
                        stop_q  <= req_stop;
                        first_q <= 1'b1;
                        abort_q <= 1'b0;
                        if (req_read) begin
                            if (req_len == 8'd0) begin
                                // A zero-length read is reported like an aborted request.
                                abort_q <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                rd_rem_q <= req_len;
                                state_q  <= ST_RD_CMD;
                            end
                        end else begin
                            state_q <= ST_WR_CMD;
                        end
                    end
                end

                ST_WR_CMD: begin
                    if (!cmd_valid_q) begin
                        cmd_addr_q  <= addr_q;
                        cmd_start_q <= 1'b1;
                        cmd_read_q  <= 1'b0;
                        cmd_wm_q    <= 1'b1;
                        cmd_stop_q  <= stop_q;
                        cmd_valid_q <= 1'b1;
                    end else if (m_axis_cmd_ready) begin
                        cmd_addr_q  <= 7'd0;
                        cmd_start_q <= 1'b0;
                        cmd_wm_q    <= 1'b0;
                        cmd_stop_q  <= 1'b0;
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end

                ST_RD_CMD: begin
                    if (!cmd_valid_q) begin
                        // Between commands: a NACK seen now or earlier diverts to STOP
                        // instead of presenting another read.
                        if (abort_q || missed_ack) begin
                            rd_rem_q <= 8'd0;
                            state_q  <= ST_STOP_CMD;
                        end else begin
                            cmd_addr_q  <= addr_q;
                            cmd_start_q <= first_q;
                            cmd_read_q  <= 1'b1;
                            cmd_wm_q    <= 1'b0;
                            cmd_stop_q  <= (rd_rem_q == 8'd1) ? stop_q : 1'b0;
                            cmd_valid_q <= 1'b1;
                        end
                    end else if (cmd_hs) begin
                        cmd_addr_q  <= 7'd0;
                        cmd_start_q <= 1'b0;
                        cmd_read_q  <= 1'b0;
                        cmd_stop_q  <= 1'b0;
                        cmd_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        // Uses only the registered flag, so a NACK coinciding with this
                        // handshake lets the handshake complete and aborts a cycle later.
                        if (abort_q) begin
                            rd_rem_q <= 8'd0;
                            state_q  <= ST_STOP_CMD;
                        end else if (rd_rem_q <= 8'd1) begin
                            rd_rem_q <= 8'd0;
                            state_q  <= ST_WAIT;
                        end else begin
                            rd_rem_q <= rd_rem_q - 8'd1;
                        end
                    end
                end

                ST_STOP_CMD: begin
                    if (!cmd_valid_q) begin
                        cmd_addr_q  <= 7'd0;
                        cmd_start_q <= 1'b0;
                        cmd_read_q  <= 1'b0;
                        cmd_wm_q    <= 1'b0;
                        cmd_stop_q  <= 1'b1;
                        cmd_valid_q <= 1'b1;
                    end else if (m_axis_cmd_ready) begin
                        cmd_stop_q  <= 1'b0;
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!master_busy && !cmd_valid_q) begin
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b1;
                    err_q   <= abort_q;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready                 = (state_q == ST_IDLE);
    assign m_axis_cmd_address        = cmd_addr_q;
    assign m_axis_cmd_start          = cmd_start_q;
    assign m_axis_cmd_read           = cmd_read_q;
    assign m_axis_cmd_write          = 1'b0;
    assign m_axis_cmd_write_multiple = cmd_wm_q;
    assign m_axis_cmd_stop           = cmd_stop_q;
    assign m_axis_cmd_valid          = cmd_valid_q;
    assign done                      = done_q;
    assign err                       = err_q;
    assign rd_remaining              = rd_rem_q;

endmodule

// File: doc/i2c_cmd_gen.md
I2C_CMD_GEN -- requirements
Module: i2c_cmd_gen

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be exactly as follows:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_address  in  7  target I2C address
- req_read  in  1  1 = read, 0 = write
- req_len  in  8  read byte count (ignored for writes)
- req_stop  in  1  end the transaction with STOP
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid and ready
- m_axis_cmd_address  out  7  to i2c_master s_axis_cmd_address
- m_axis_cmd_start  out  1  to i2c_master s_axis_cmd_start
- m_axis_cmd_read  out  1  to i2c_master s_axis_cmd_read
- m_axis_cmd_write  out  1  to i2c_master s_axis_cmd_write (always 0)
- m_axis_cmd_write_multiple  out  1  to i2c_master s_axis_cmd_write_multiple
- m_axis_cmd_stop  out  1  to i2c_master s_axis_cmd_stop
- m_axis_cmd_valid  out  1  command valid
- m_axis_cmd_ready  in  1  from i2c_master s_axis_cmd_ready
- master_busy  in  1  from i2c_master busy
- missed_ack  in  1  from i2c_master missed_ack
- done  out  1  one-cycle pulse when the request completes
- err  out  1  valid with done: 1 = NACK seen or bad request
- rd_remaining  out  8  read commands not yet issued

Function
REQ-003 States SHALL be IDLE, RD_CMD, WR_CMD, STOP_CMD, WAIT, DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; acceptance latches address, read, len and stop, and clears the abort flag.
REQ-005 On acceptance of a read with req_len=0, the block SHALL go to DONE with err=1 and issue no command.
REQ-006 On acceptance of a read with req_len=N>0, the block SHALL go to RD_CMD with rd_remaining=N.
REQ-007 On acceptance of a write, the block SHALL go to WR_CMD.
REQ-008 m_axis_cmd_valid SHALL assert in the cycle after entering RD_CMD, WR_CMD or STOP_CMD (1-cycle latency from acceptance).
REQ-009 While m_axis_cmd_valid=1 and m_axis_cmd_ready=0, all m_axis_cmd_* outputs SHALL be held stable; valid SHALL never drop before the handshake.
REQ-010 WR_CMD SHALL present the command address=latched, write_multiple=1, start=1, stop=latched stop.
REQ-011 After the WR_CMD handshake, the block SHALL go to WAIT.
REQ-012 RD_CMD SHALL present the command read=1, address=latched.
REQ-013 In RD_CMD, start SHALL be 1 only on the first command of the request.
REQ-014 In RD_CMD, stop SHALL equal the latched stop only on the command with rd_remaining=1, and SHALL be 0 otherwise.
REQ-015 Each RD_CMD handshake SHALL decrement rd_remaining by 1.
REQ-016 When the decrement reaches 0, the block SHALL go to WAIT.
REQ-017 Otherwise, valid SHALL deassert for one cycle and the next command SHALL be presented.
REQ-018 A missed_ack=1 in any cycle outside IDLE/DONE SHALL set a sticky abort flag.
REQ-019 In RD_CMD with abort set, at the next handshake, or immediately if valid=0, the block SHALL go to STOP_CMD.
REQ-020 STOP_CMD SHALL present stop=1 with all other command bits 0, then go to WAIT after the handshake.
REQ-021 WAIT SHALL go to DONE on the first cycle with master_busy=0 and valid=0.
REQ-022 DONE SHALL last one cycle: done=1, err=abort flag (or 1 per REQ-005), then go to IDLE.
REQ-023 rd_remaining SHALL never underflow, and SHALL be forced to 0 by an abort.
REQ-024 Simultaneous missed_ack and handshake SHALL complete the handshake first, then apply the abort.

Reset
REQ-025 While rst=1, the block SHALL be in IDLE with req_ready=1, all m_axis_cmd_* outputs 0, done=0, err=0, rd_remaining=0, and the abort flag clear.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no STOP command and no done pulse.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Write, addr 0x22, stop=1, ready always 1 -> one command {0x22, write_multiple=1, start=1, stop=1}; done=1, err=0 after busy falls.
- Read, addr 0x2A, len=3, stop=1 -> three read commands with start=1,0,0 and stop=0,0,1; rd_remaining 3→2→1→0; done with err=0.
- Read, len=4, m_axis_cmd_ready held 0 for 5 cycles -> command fields stable for all 5 cycles; exactly 4 handshakes.
- Read, addr 0x37, len=5, missed_ack pulse after first handshake -> one stop-only command follows; done=1, err=1; rd_remaining=0.
- Read, len=0 -> no m_axis_cmd_valid; done=1, err=1 two cycles after acceptance.
- rst asserted during the second read command -> outputs zero asynchronously; req_ready=1 after release; no done pulse.
